// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: FSM state, event pulse bundle, default word width.
// No logic; pure declarations.
// No flow control; consumers decide how the types are registered.
package spi_pkg;

    localparam int SPI_DW_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic overrun;
        logic underrun;
        logic abort;
    } spi_evt_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an async input with rise/fall pulses one stage later.
// Latency: STAGES clocks to sync_o; edge pulses valid in the same cycle sync_o changes.
// No backpressure; pulses are single-cycle and must be consumed when asserted.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave, all four cpol/cpha modes, one-word tx buffer and one-word rx holding register.
// Latency: SYNC_STAGES+1 clocks from any pin edge to internal action; rx word one clock after last sample.
// tx side: tx_ready low while buffer full; rx side: unread word is overwritten and flagged, never stalls the bus.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DW_DEFAULT,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  sclk_i,
    input  logic                  cs_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  rx_overrun_o,
    output logic                  tx_underrun_o,
    output logic                  frame_abort_o
);

    localparam int            CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam bit            LSB  = (LSB_FIRST != 0);

    spi_state_e              state_q;
    logic [CW-1:0]           bit_cnt_q;
    logic [DATA_WIDTH-1:0]   tx_sh_q;
    logic [DATA_WIDTH-2:0]   rx_sh_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    rx_valid_q;
    spi_evt_t                evt_q;
    logic [DATA_WIDTH-1:0]   txbuf_q, txbuf_d;
    logic                    txbuf_full_q, txbuf_full_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q;
    logic [1:0]              settle_q;
    logic                    armed_q;

    logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s;
    logic sclk_edge, lead_ev, trail_ev, in_shift, sample_ev, shift_ev;
    logic word_done, start, load, consume, accept;
    logic [DATA_WIDTH-1:0] load_word, rx_word, tx_shifted;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (sclk_i),
        .sync_o  (sclk_s),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (cs_i),
        .sync_o  (cs_s),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The cs chain holds its reset value until flushed; only a real high arms frame entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
            armed_q <= armed_q | ((settle_q == 2'd3) & cs_s);
        end
    end

    // Leading edge is the one that moves sclk away from its idle level.
    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead_ev   = sclk_edge & (sclk_s ^ cpol_i);
    assign trail_ev  = sclk_edge & ~(sclk_s ^ cpol_i);
    assign in_shift  = (state_q == ST_SHIFT) & ~cs_rise;
    assign sample_ev = in_shift & (cpha_i ? trail_ev : lead_ev);
    assign shift_ev  = in_shift & (cpha_i ? lead_ev : trail_ev) & (bit_cnt_q != '0);
    assign word_done = sample_ev & (bit_cnt_q == LAST);
    assign start     = (state_q == ST_IDLE) & cs_fall & armed_q;
    assign load      = start | word_done;
    assign consume   = load & txbuf_full_q;
    assign accept    = tx_valid_i & ~txbuf_full_q;

    assign load_word  = txbuf_full_q ? txbuf_q : '0;
    assign rx_word    = LSB ? {mosi_s, rx_sh_q} : {rx_sh_q, mosi_s};
    assign tx_shifted = LSB ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]} : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};

    always_comb begin
        txbuf_full_d = txbuf_full_q;
        txbuf_d      = txbuf_q;
        if (consume) txbuf_full_d = 1'b0;
        if (accept) begin
            txbuf_full_d = 1'b1;
            txbuf_d      = tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            txbuf_q      <= '0;
            txbuf_full_q <= 1'b0;
        end else begin
            txbuf_q      <= txbuf_d;
            txbuf_full_q <= txbuf_full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            evt_q      <= '0;
        end else begin
            evt_q <= '0;
            if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q        <= ST_SHIFT;
                        bit_cnt_q      <= '0;
                        tx_sh_q        <= load_word;
                        evt_q.underrun <= ~txbuf_full_q;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state_q     <= ST_IDLE;
                        bit_cnt_q   <= '0;
                        evt_q.abort <= (bit_cnt_q != '0);
                    end else begin
                        if (word_done) begin
                            bit_cnt_q      <= '0;
                            rx_data_q      <= rx_word;
                            rx_valid_q     <= 1'b1;
                            evt_q.overrun  <= rx_valid_q & ~rx_ready_i;
                            tx_sh_q        <= load_word;
                            evt_q.underrun <= ~txbuf_full_q;
                        end else if (sample_ev) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            rx_sh_q   <= LSB ? rx_word[DATA_WIDTH-1:1] : rx_word[DATA_WIDTH-2:0];
                        end
                        if (shift_ev) tx_sh_q <= tx_shifted;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso_o        = (state_q == ST_SHIFT) & (LSB ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1]);
    assign tx_ready_o    = ~txbuf_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign rx_overrun_o  = evt_q.overrun;
    assign tx_underrun_o = evt_q.underrun;
    assign frame_abort_o = evt_q.abort;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: SPI master stimulus, scoreboard queues for rx words,
// monitor process counting event pulses against a word-level model.
module tb_spi_slave_param;

    localparam int W = 8;
    localparam int H = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, cpol, cpha, sclk, mosi;
    logic [1:0]   cs, miso, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [1:0]   rx_overrun, tx_underrun, frame_abort;
    logic [W-1:0] tx_data [2];
    logic [W-1:0] rx_data [2];

    spi_slave_param #(.DATA_WIDTH(W), .LSB_FIRST(0), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .reset_i(reset), .cpol_i(cpol), .cpha_i(cpha), .sclk_i(sclk),
        .cs_i(cs[0]), .mosi_i(mosi), .miso_o(miso[0]),
        .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]),
        .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .rx_ready_i(rx_ready[0]),
        .rx_overrun_o(rx_overrun[0]), .tx_underrun_o(tx_underrun[0]), .frame_abort_o(frame_abort[0])
    );

    spi_slave_param #(.DATA_WIDTH(W), .LSB_FIRST(1), .SYNC_STAGES(3)) dut_l (
        .clk_i(clk), .reset_i(reset), .cpol_i(cpol), .cpha_i(cpha), .sclk_i(sclk),
        .cs_i(cs[1]), .mosi_i(mosi), .miso_o(miso[1]),
        .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]),
        .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .rx_ready_i(rx_ready[1]),
        .rx_overrun_o(rx_overrun[1]), .tx_underrun_o(tx_underrun[1]), .frame_abort_o(frame_abort[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    bit           m_txv [2];
    logic [W-1:0] m_txw [2];
    int           exp_und [2], exp_ovr [2], exp_abt [2];
    int           got_und [2], got_ovr [2], got_abt [2];
    bit           hold, pend_v;
    logic [W-1:0] pend_w;
    logic [W-1:0] exp_rx0 [$];
    logic [W-1:0] exp_rx1 [$];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: counts event pulses and pops the scoreboard on every rx handshake.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (tx_underrun[k]) got_und[k]++;
                if (rx_overrun[k])  got_ovr[k]++;
                if (frame_abort[k]) got_abt[k]++;
            end
            if (rx_valid[0] && rx_ready[0]) begin
                if (exp_rx0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rx0_extra: got word %02h, none expected", rx_data[0]);
                end else check("rx0_word", rx_data[0], exp_rx0.pop_front());
            end
            if (rx_valid[1] && rx_ready[1]) begin
                if (exp_rx1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rx1_extra: got word %02h, none expected", rx_data[1]);
                end else check("rx1_word", rx_data[1], exp_rx1.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p; cpha = h; sclk = p;
        wait_clk(6);
    endtask

    function automatic void model_rx(input int inst, input logic [W-1:0] w);
        if (inst == 1) exp_rx1.push_back(w);
        else if (hold) begin
            if (pend_v) exp_ovr[0]++;
            pend_v = 1'b1;
            pend_w = w;
        end else exp_rx0.push_back(w);
    endfunction

    task automatic load_tx(input int inst, input logic [W-1:0] w);
        int t;
        t = 0;
        tx_data[inst] = w;
        tx_valid[inst] = 1'b1;
        while (tx_ready[inst] !== 1'b1 && t < 20) begin
            wait_clk(1);
            t++;
        end
        check("tx_ready_wait", (t < 20), 1);
        wait_clk(1);
        tx_valid[inst] = 1'b0;
        m_txv[inst] = 1'b1;
        m_txw[inst] = w;
        check("tx_ready_full", tx_ready[inst], 0);
    endtask

    // One cs-low frame of nw words; abort_at>0 cuts the last word after that many bits.
    task automatic frame(input int inst, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int nw, input int abort_at);
        logic [W-1:0] w, rd, exp_miso;
        int nb, idx, ncomp;
        bit had_tx;
        ncomp  = (abort_at > 0) ? nw - 1 : nw;
        had_tx = m_txv[inst];
        exp_und[inst] += (had_tx ? 0 : 1) + ncomp;
        m_txv[inst] = 1'b0;
        if (abort_at > 0) exp_abt[inst]++;
        cs[inst] = 1'b0;
        for (int k = 0; k < nw; k++) begin
            w        = (k == 0) ? w0 : w1;
            nb       = (abort_at > 0 && k == nw - 1) ? abort_at : W;
            exp_miso = (k == 0 && had_tx) ? m_txw[inst] : '0;
            if (nb == W) model_rx(inst, w);
            rd = '0;
            for (int b = 0; b < nb; b++) begin
                idx = (inst == 1) ? b : W - 1 - b;
                if (!cpha) begin
                    mosi = w[idx];
                    wait_clk(H);
                    rd[idx] = miso[inst];
                    sclk = ~cpol;
                    wait_clk(H);
                    sclk = cpol;
                end else begin
                    wait_clk(H);
                    sclk = ~cpol;
                    mosi = w[idx];
                    wait_clk(H);
                    rd[idx] = miso[inst];
                    sclk = cpol;
                end
            end
            if (nb == W) check($sformatf("miso_word%0d_inst%0d", k, inst), rd, exp_miso);
        end
        wait_clk(H);
        cs[inst] = 1'b1;
        wait_clk(10);
        check("underrun_count", got_und[inst], exp_und[inst]);
        check("overrun_count", got_ovr[inst], exp_ovr[inst]);
        check("abort_count", got_abt[inst], exp_abt[inst]);
    endtask

    task automatic free_bits(input int n);
        for (int b = 0; b < n; b++) begin
            mosi = 1'($urandom_range(0, 1));
            wait_clk(H);
            sclk = ~cpol;
            wait_clk(H);
            sclk = cpol;
        end
    endtask

    initial begin
        int nw, ab;
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
        cs = 2'b11; tx_valid = 2'b00; rx_ready = 2'b11;
        tx_data[0] = '0; tx_data[1] = '0;
        hold = 1'b0; pend_v = 1'b0; pend_w = '0;
        for (int k = 0; k < 2; k++) begin
            m_txv[k] = 1'b0; m_txw[k] = '0;
            exp_und[k] = 0; exp_ovr[k] = 0; exp_abt[k] = 0;
            got_und[k] = 0; got_ovr[k] = 0; got_abt[k] = 0;
        end
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_tx_ready%0d", k), tx_ready[k], 1);
            check($sformatf("reset_rx_valid%0d", k), rx_valid[k], 0);
            check($sformatf("reset_miso%0d", k), miso[k], 0);
            check($sformatf("reset_rx_data%0d", k), rx_data[k], 0);
        end
        wait_clk(6);

        set_mode(1'b0, 1'b0);
        load_tx(0, 8'hA5);
        frame(0, 8'hAD, 8'h00, 1, 0);

        set_mode(1'b1, 1'b1);
        load_tx(0, 8'h3C);
        frame(0, 8'h69, 8'h00, 1, 0);

        set_mode(1'b0, 1'b0);
        hold = 1'b1;
        rx_ready[0] = 1'b0;
        load_tx(0, 8'h5A);
        frame(0, 8'h12, 8'h34, 2, 0);
        check("hold_rx_valid", rx_valid[0], 1);
        check("hold_rx_data", rx_data[0], 8'h34);
        exp_rx0.push_back(pend_w);
        pend_v = 1'b0;
        hold = 1'b0;
        rx_ready[0] = 1'b1;
        wait_clk(3);
        check("rx_valid_after_read", rx_valid[0], 0);

        set_mode(1'b0, 1'b1);
        frame(0, 8'hC3, 8'h00, 1, 0);

        set_mode(1'b0, 1'b0);
        load_tx(0, 8'h96);
        frame(0, 8'hFF, 8'h00, 1, 5);
        check("abort_rx_valid", rx_valid[0], 0);
        frame(0, 8'hF0, 8'h00, 1, 0);

        load_tx(0, 8'h77);
        cs[0] = 1'b0;
        free_bits(3);
        reset = 1'b1;
        m_txv[0] = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        free_bits(4);
        check("reset_midframe_miso", miso[0], 0);
        free_bits(4);
        wait_clk(H);
        cs[0] = 1'b1;
        wait_clk(10);
        check("reset_midframe_rx_valid", rx_valid[0], 0);
        check("reset_midframe_tx_ready", tx_ready[0], 1);
        check("reset_midframe_abort", got_abt[0], exp_abt[0]);
        check("reset_midframe_underrun", got_und[0], exp_und[0]);
        frame(0, 8'h5C, 8'h00, 1, 0);

        for (int r = 0; r < 12; r++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) load_tx(0, W'($urandom));
            nw = $urandom_range(1, 2);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : 0;
            frame(0, W'($urandom), W'($urandom), nw, ab);
        end

        set_mode(1'b0, 1'b0);
        frame(1, 8'h01, 8'h00, 1, 0);
        set_mode(1'b1, 1'b0);
        frame(1, 8'hB2, 8'h4E, 2, 0);

        wait_clk(5);
        check("rx0_queue_drained", exp_rx0.size(), 0);
        check("rx1_queue_drained", exp_rx1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
